// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
//   Round-robin arbiter that lets N requesters drive a shared W-bit bank of
//   SR flip-flops. A winner's opcode is turned into registered set/reset
//   vectors for exactly one cycle, followed by at least one quiet cycle so
//   the bank state q is settled before the next opcode is computed from it.
//
//   Opcodes: 00 SET, 01 CLR, 10 LOAD, 11 TOGGLE.
//
//   Optional feature: define SRARB_LOCK_EN to enable ownership locking. A
//   requester granted with its lock bit high keeps the bank (OWN state) and
//   may issue further ops back to back until it drops lock. Without the
//   macro, the lock port is present but ignored and OWN is never entered.
//
//   Reset: rst is synchronous and active-high. s, r and gnt are also forced
//   low while rst is high, so an op aborted by rst in ISSUE never reaches
//   the bank and q keeps its previous value.
//
//   The round-robin index arithmetic wraps modulo 2**clog2(N), which equals N
//   for the supported N=4.

module sr_bank_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   op,
  input  logic [W*N-1:0]   data,
  input  logic [N-1:0]     lock,
  input  logic [W-1:0]     q,
  output logic [W-1:0]     s,
  output logic [W-1:0]     r,
  output logic [N-1:0]     gnt,
  output logic             busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    OWN   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLR    = 2'b01,
    OP_LOAD   = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  state_e          state;
  logic [PW-1:0]   p;
  logic [W-1:0]    s_q;
  logic [W-1:0]    r_q;
  logic [N-1:0]    gnt_q;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic            issue_go;
  logic [PW-1:0]   issue_idx;
  op_e             issue_op;
  logic [W-1:0]    issue_data;
  logic [W-1:0]    issue_s;
  logic [W-1:0]    issue_r;

`ifdef SRARB_LOCK_EN
  logic [PW-1:0]   owner;
  logic            own_lock;
`else
  logic            unused_lock;
  assign unused_lock = ^lock;
`endif

  // Round-robin search over req starting at pointer p.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[p + PW'(k)]) begin
        win_found = 1'b1;
        win_idx   = p + PW'(k);
      end
    end
  end

  // Decide whether an op is issued this cycle and for which requester.
  always_comb begin
    issue_go  = 1'b0;
    issue_idx = win_idx;
    if (state == IDLE) begin
      issue_go = win_found;
    end
`ifdef SRARB_LOCK_EN
    else if (state == OWN && req[owner]) begin
      issue_go  = 1'b1;
      issue_idx = owner;
    end
`endif
  end

  assign issue_op   = op_e'(op[2*issue_idx +: 2]);
  assign issue_data = data[W*issue_idx +: W];

  // Translate the selected opcode into non-overlapping set/reset vectors.
  always_comb begin
    issue_s = '0;
    issue_r = '0;
    case (issue_op)
      OP_SET:    issue_s = issue_data;
      OP_CLR:    issue_r = issue_data;
      OP_LOAD: begin
        issue_s = issue_data;
        issue_r = ~issue_data;
      end
      OP_TOGGLE: begin
        issue_s = issue_data & ~q;
        issue_r = issue_data & q;
      end
      default: ;
    endcase
  end

  // Arbiter FSM with registered set/reset/grant outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      s_q   <= '0;
      r_q   <= '0;
      gnt_q <= '0;
`ifdef SRARB_LOCK_EN
      owner    <= '0;
      own_lock <= 1'b0;
`endif
    end else begin
      // Outputs are pulses: zero unless an op is issued on this edge.
      s_q   <= '0;
      r_q   <= '0;
      gnt_q <= '0;
      if (issue_go) begin
        state <= ISSUE;
        s_q   <= issue_s;
        r_q   <= issue_r;
        gnt_q <= N'(1) << issue_idx;
`ifdef SRARB_LOCK_EN
        owner    <= issue_idx;
        own_lock <= lock[issue_idx];
        // A locking owner keeps the pointer until it releases.
        if (!lock[issue_idx]) p <= issue_idx + PW'(1);
`else
        p <= issue_idx + PW'(1);
`endif
      end else begin
        case (state)
`ifdef SRARB_LOCK_EN
          ISSUE: state <= own_lock ? OWN : IDLE;
          OWN: begin
            if (!lock[owner]) begin
              state <= IDLE;
              p     <= owner + PW'(1);
            end
          end
`else
          ISSUE: state <= IDLE;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Reset masks the pulses immediately so an aborted op never hits the bank.
  assign s    = s_q & {W{~rst}};
  assign r    = r_q & {W{~rst}};
  assign gnt  = gnt_q & {N{~rst}};
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Testbench for sr_bank_arbiter: models the SR bank, queues expected
// grant/set/reset pulses as requests are driven and compares them when the
// DUT raises gnt.

module tb_sr_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  op = '0;
  logic [31:0] data = '0;
  logic [3:0]  lock = '0;
  logic [7:0]  bank = 8'h00;
  logic [7:0]  s;
  logic [7:0]  r;
  logic [3:0]  gnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] s;
    logic [7:0] r;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] prev_gnt = '0;

  sr_bank_arbiter #(.W(8), .N(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .op   (op),
    .data (data),
    .lock (lock),
    .q    (bank),
    .s    (s),
    .r    (r),
    .gnt  (gnt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // SR flip-flop bank driven by the DUT.
  always @(posedge clk) bank <= (bank & ~r) | s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [7:0] sv, input logic [7:0] rv);
    exp_t e;
    e.g = g;
    e.s = sv;
    e.r = rv;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
  endtask

  // Raise req for every bit of mask; each requester drops after its grant.
  task automatic run_reqs(input logic [3:0] mask, input string tag);
    int cyc;
    int last;
    int ngr;
    cyc  = 0;
    last = 0;
    ngr  = 0;
    req  = mask;
    while (req != 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if ((gnt & req) != 0) begin
        if (ngr == 0) check({tag, "_latency"}, cyc, 1);
        else          check({tag, "_gap"}, cyc - last, 2);
        last = cyc;
        ngr++;
        req = req & ~gnt;
      end
    end
    if (req != 0) begin
      check({tag, "_timeout"}, {28'd0, req}, 0);
      req = '0;
    end
  endtask

  // Scoreboard monitor: pops an expectation for every grant pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
    end else begin
      if (gnt != 0) begin
        check("sr_overlap", s & r, 0);
        check("back_to_back", prev_gnt, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", gnt, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("gnt", gnt, mon_e.g);
          check("s", s, mon_e.s);
          check("r", r, mon_e.r);
        end
      end else begin
        check("quiet_sr", s | r, 0);
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int cyc;

    do_reset();

    // SET A5 from requester 0.
    op[1:0]   = 2'b00;
    data[7:0] = 8'hA5;
    push_exp(4'b0001, 8'hA5, 8'h00);
    run_reqs(4'b0001, "set_a5");
    check("busy_in_issue", busy, 1);
    settle();
    check("post_set_gnt", gnt, 0);
    check("post_set_s", s, 0);
    check("post_set_r", r, 0);
    check("post_set_busy", busy, 0);
    check("q_a5", bank, 8'hA5);

    // LOAD F0 then TOGGLE 3C from requester 2.
    op[5:4]     = 2'b10;
    data[23:16] = 8'hF0;
    push_exp(4'b0100, 8'hF0, 8'h0F);
    run_reqs(4'b0100, "load_f0");
    settle();
    check("q_f0", bank, 8'hF0);
    op[5:4]     = 2'b11;
    data[23:16] = 8'h3C;
    push_exp(4'b0100, 8'h0C, 8'h30);
    run_reqs(4'b0100, "toggle_3c");
    settle();
    check("q_cc", bank, 8'hCC);

    // LOAD FF, LOAD 5A, then CLR FF aborted by reset in ISSUE.
    op[7:6]     = 2'b10;
    data[31:24] = 8'hFF;
    push_exp(4'b1000, 8'hFF, 8'h00);
    run_reqs(4'b1000, "load_ff");
    settle();
    check("q_ff", bank, 8'hFF);
    data[31:24] = 8'h5A;
    push_exp(4'b1000, 8'h5A, 8'hA5);
    run_reqs(4'b1000, "load_5a");
    settle();
    check("q_5a", bank, 8'h5A);
    op[7:6]     = 2'b01;
    data[31:24] = 8'hFF;
    req = 4'b1000;
    @(posedge clk);
    #1;
    check("abort_gnt", gnt, 4'b1000);
    check("abort_r_pre", r, 8'hFF);
    rst = 1'b1;
    req = '0;
    #1;
    check("abort_s_masked", s, 0);
    check("abort_r_masked", r, 0);
    check("abort_gnt_masked", gnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_q_hold", bank, 8'h5A);
    settle();
    check("abort_s", s, 0);
    check("abort_r", r, 0);
    check("abort_gnt_after", gnt, 0);
    check("abort_q_hold2", bank, 8'h5A);

    // All four request at once from p=0.
    op   = {2'b00, 2'b10, 2'b01, 2'b00};
    data = {8'h80, 8'h33, 8'h02, 8'h01};
    push_exp(4'b0001, 8'h01, 8'h00);
    push_exp(4'b0010, 8'h00, 8'h02);
    push_exp(4'b0100, 8'h33, 8'hCC);
    push_exp(4'b1000, 8'h80, 8'h00);
    run_reqs(4'b1111, "rr4");
    settle();
    check("rr4_busy_done", busy, 0);

    // Ownership lock: requester 0 issues three ops while requester 1 waits.
    do_reset();
    op[1:0]    = 2'b00;
    data[7:0]  = 8'h11;
    op[3:2]    = 2'b01;
    data[15:8] = 8'h01;
`ifdef SRARB_LOCK_EN
    push_exp(4'b0001, 8'h11, 8'h00);
    push_exp(4'b0001, 8'h11, 8'h00);
    push_exp(4'b0001, 8'h11, 8'h00);
    push_exp(4'b0010, 8'h00, 8'h01);
`else
    push_exp(4'b0001, 8'h11, 8'h00);
    push_exp(4'b0010, 8'h00, 8'h01);
    push_exp(4'b0001, 8'h11, 8'h00);
    push_exp(4'b0001, 8'h11, 8'h00);
`endif
    req  = 4'b0011;
    lock = 4'b0001;
    cnt0 = 0;
    cyc  = 0;
    while (req != 0 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (gnt[0]) begin
        cnt0++;
        if (cnt0 == 3) begin
          req[0]  = 1'b0;
          lock[0] = 1'b0;
        end
      end
      if (gnt[1]) req[1] = 1'b0;
    end
    if (req != 0) begin
      check("lock_timeout", {28'd0, req}, 0);
      req  = '0;
      lock = '0;
    end
    check("lock_owner_ops", cnt0, 3);
    repeat (2) settle();
    check("lock_busy_done", busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
